uart_waveform_rx: RTL and testbench

//  Receive side of the ADC waveform serial link: deserialises a 1-start/8-data/1-stop (LSB first) bitstream
//  and rebuilds a 32-sample x 14-bit waveform from 3-byte records {sample[13:8], sample[7:0], index}.

---
 rtl/uart_wave_pkg.sv | 20 ++
 rtl/uart_waveform_rx_if.sv | 24 ++
 rtl/uart_byte_rx.sv | 112 +++++++++++
 rtl/uart_waveform_rx.sv | 98 +++++++++
 tb/tb_uart_waveform_rx.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_wave_pkg.sv
// rtl/uart_wave_pkg.sv - shared sizes, types and helpers for the waveform serial receiver
package uart_wave_pkg;
    localparam int N_SAMPLES = 32;
    localparam int SAMPLE_W  = 14;
    localparam int REC_BYTES = 3;
    localparam int IDX_W     = $clog2(N_SAMPLES);

    typedef logic [SAMPLE_W-1:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } rx_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction
endpackage

// File: rtl/uart_waveform_rx_if.sv
// rtl/uart_waveform_rx_if.sv - serial input, control and waveform result bundle of the receiver
interface uart_waveform_rx_if;
    import uart_wave_pkg::*;

    logic                 rx;
    logic                 clear;
    sample_t              waveform [N_SAMPLES];
    logic [N_SAMPLES-1:0] sample_mask;
    logic                 waveform_valid;
    logic                 frame_err;
    logic                 record_err;
    logic [7:0]           byte_data;
    logic                 byte_valid;

    modport master (
        output rx, clear,
        input  waveform, sample_mask, waveform_valid, frame_err, record_err, byte_data, byte_valid
    );

    modport slave (
        input  rx, clear,
        output waveform, sample_mask, waveform_valid, frame_err, record_err, byte_data, byte_valid
    );
endinterface

// File: rtl/uart_byte_rx.sv
// rtl/uart_byte_rx.sv - 8N1 byte deserialiser; RX_MAJORITY_VOTE_EN selects 3-sample majority per bit
module uart_byte_rx
    import uart_wave_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_i,
    input  logic       clear_i,
    output logic [7:0] byte_data_o,
    output logic       byte_valid_o,
    output logic       frame_err_o,
    output logic       idle_o
);
    localparam int            CW        = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    // Decisions are taken one clock after mid-bit so both builds share identical timing.
    localparam logic [CW-1:0] START_CHK = CW'(CLKS_PER_BIT / 2 + 1);

    rx_state_e     state_q;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic          bit_val;
    logic [CW-1:0] cnt_q;
    logic [2:0]    bit_idx_q;
    logic [7:0]    shift_q, data_q;
    logic          valid_q, ferr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {rx_meta_q, rx_sync_q, rx_prev_q} <= 3'b111;
        else        {rx_meta_q, rx_sync_q, rx_prev_q} <= {rx_i, rx_meta_q, rx_sync_q};
    end

`ifdef RX_MAJORITY_VOTE_EN
    logic rx_prev2_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rx_prev2_q <= 1'b1;
        else        rx_prev2_q <= rx_prev_q;
    end
    assign bit_val = maj3(rx_prev2_q, rx_prev_q, rx_sync_q);
`else
    assign bit_val = rx_prev_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else if (clear_i) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            cnt_q   <= cnt_q + 1'b1;
            case (state_q)
                // Edge-triggered start: a held-low break cannot retrigger until the line rises.
                IDLE: begin
                    if (!rx_sync_q && rx_prev_q) begin
                        state_q <= START;
                        cnt_q   <= CW'(1);
                    end else begin
                        cnt_q <= '0;
                    end
                end
                START: begin
                    if (cnt_q == START_CHK) begin
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        state_q   <= bit_val ? IDLE : DATA;
                    end
                end
                DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q     <= '0;
                        shift_q   <= {bit_val, shift_q[7:1]};
                        bit_idx_q <= bit_idx_q + 1'b1;
                        if (bit_idx_q == 3'd7) state_q <= STOP;
                    end
                end
                STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                        if (bit_val) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end else begin
                            ferr_q <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign byte_data_o  = data_q;
    assign byte_valid_o = valid_q;
    assign frame_err_o  = ferr_q;
    assign idle_o       = (state_q == IDLE);
endmodule

// File: rtl/uart_waveform_rx.sv
// rtl/uart_waveform_rx.sv - record assembler and 32x14 waveform buffer; RX_MAJORITY_VOTE_EN passes to uart_byte_rx
module uart_waveform_rx
    import uart_wave_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int GAP_TIMEOUT  = 30
) (
    input  logic               clk,
    input  logic               rst_n,
    uart_waveform_rx_if.slave  bus
);
    localparam int                   GAP_CLKS = GAP_TIMEOUT * CLKS_PER_BIT;
    localparam int                   GW       = $clog2(GAP_CLKS);
    localparam logic [GW-1:0]        GAP_LAST = GW'(GAP_CLKS - 1);
    localparam logic [1:0]           POS_LAST = 2'(REC_BYTES - 1);
    localparam logic [N_SAMPLES-1:0] ALL_SET  = '1;

    logic [7:0]           b_data;
    logic                 b_valid, b_ferr, b_idle;
    logic [1:0]           pos_q;
    logic [7:0]           hi_q, lo_q;
    logic [GW-1:0]        gap_q;
    sample_t              wave_q [N_SAMPLES];
    logic [N_SAMPLES-1:0] mask_q, mask_d;
    logic                 wv_q, ferr_q, rerr_q;
    logic [IDX_W-1:0]     idx;
    logic                 rec_ok;

    uart_byte_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_byte (
        .clk          (clk),
        .rst_n        (rst_n),
        .rx_i         (bus.rx),
        .clear_i      (bus.clear),
        .byte_data_o  (b_data),
        .byte_valid_o (b_valid),
        .frame_err_o  (b_ferr),
        .idle_o       (b_idle)
    );

    assign idx    = b_data[IDX_W-1:0];
    assign rec_ok = (hi_q[7:6] == 2'b00) && (b_data[7:IDX_W] == '0);
    assign mask_d = mask_q | (N_SAMPLES'(1) << idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos_q <= '0; hi_q <= '0; lo_q <= '0; gap_q <= '0;
            mask_q <= '0; wv_q <= 1'b0; ferr_q <= 1'b0; rerr_q <= 1'b0;
            for (int i = 0; i < N_SAMPLES; i++) wave_q[i] <= '0;
        end else if (bus.clear) begin
            pos_q <= '0; hi_q <= '0; lo_q <= '0; gap_q <= '0;
            mask_q <= '0; wv_q <= 1'b0; ferr_q <= 1'b0; rerr_q <= 1'b0;
            for (int i = 0; i < N_SAMPLES; i++) wave_q[i] <= '0;
        end else begin
            wv_q <= 1'b0;
            if (b_ferr) begin
                ferr_q <= 1'b1;
                pos_q  <= '0;
                gap_q  <= '0;
            end else if (b_valid) begin
                gap_q <= '0;
                if (pos_q == 2'd0) begin
                    hi_q  <= b_data;
                    pos_q <= 2'd1;
                end else if (pos_q != POS_LAST) begin
                    lo_q  <= b_data;
                    pos_q <= pos_q + 1'b1;
                end else begin
                    pos_q <= '0;
                    if (rec_ok) begin
                        wave_q[idx] <= {hi_q[5:0], lo_q};
                        mask_q      <= mask_d;
                        wv_q        <= (mask_q != ALL_SET) && (mask_d == ALL_SET);
                    end else begin
                        rerr_q <= 1'b1;
                    end
                end
            // A stalled partial record is abandoned so the next byte starts a fresh record.
            end else if (b_idle && pos_q != 2'd0) begin
                if (gap_q == GAP_LAST) begin
                    pos_q <= '0;
                    gap_q <= '0;
                end else begin
                    gap_q <= gap_q + 1'b1;
                end
            end else begin
                gap_q <= '0;
            end
        end
    end

    assign bus.waveform       = wave_q;
    assign bus.sample_mask    = mask_q;
    assign bus.waveform_valid = wv_q;
    assign bus.frame_err      = ferr_q;
    assign bus.record_err     = rerr_q;
    assign bus.byte_data      = b_data;
    assign bus.byte_valid     = b_valid;
endmodule

// File: tb/tb_uart_waveform_rx.sv
// tb/tb_uart_waveform_rx.sv - directed and randomized record-level checks of uart_waveform_rx
module tb_uart_waveform_rx;
    import uart_wave_pkg::*;

    localparam int CPB = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_waveform_rx_if bus();

    uart_waveform_rx #(.CLKS_PER_BIT(CPB), .GAP_TIMEOUT(30)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    int dut_pulses = 0;
    int pulse_base = 0;
    int n_bytes = 0;
    logic [7:0] last_byte = 8'h00;

    always @(negedge clk) begin
        if (bus.waveform_valid) dut_pulses++;
        if (bus.byte_valid) begin
            n_bytes++;
            last_byte = bus.byte_data;
        end
    end

    logic [13:0] m_wave [32];
    logic [31:0] m_mask;
    logic        m_ferr, m_rerr;
    int          m_pulses;
    logic [7:0]  m_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 32; i++) m_wave[i] = '0;
        m_mask = '0; m_ferr = 1'b0; m_rerr = 1'b0; m_pulses = 0;
        m_q.delete();
        pulse_base = dut_pulses;
    endtask

    task automatic m_byte(input logic [7:0] b);
        logic [7:0] hi, lo, ix;
        logic       was_full;
        m_q.push_back(b);
        if (m_q.size() == 3) begin
            hi = m_q[0]; lo = m_q[1]; ix = m_q[2];
            m_q.delete();
            if (hi[7:6] == 2'b00 && ix < 8'd32) begin
                was_full = (m_mask == 32'hFFFF_FFFF);
                m_wave[ix[4:0]] = {hi[5:0], lo};
                m_mask[ix[4:0]] = 1'b1;
                if (!was_full && m_mask == 32'hFFFF_FFFF) m_pulses++;
            end else begin
                m_rerr = 1'b1;
            end
        end
    endtask

    task automatic send_bit(input logic v);
        bus.rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        int n0;
        n0 = n_bytes;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop);
        send_bit(1'b1);
        check("byte_cnt", n_bytes - n0, stop ? 1 : 0);
        if (stop) begin
            check("byte_data", last_byte, b);
            m_byte(b);
        end else begin
            m_ferr = 1'b1;
            m_q.delete();
        end
    endtask

    task automatic send_record(input logic [13:0] s, input logic [7:0] ix);
        send_byte({2'b00, s[13:8]}, 1'b1);
        send_byte(s[7:0], 1'b1);
        send_byte(ix, 1'b1);
    endtask

    task automatic do_clear();
        @(negedge clk) bus.clear = 1'b1;
        @(negedge clk) bus.clear = 1'b0;
        m_reset();
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 32; i++) check({tag, "_wave"}, bus.waveform[i], m_wave[i]);
        check({tag, "_mask"}, bus.sample_mask, m_mask);
        check({tag, "_ferr"}, bus.frame_err, m_ferr);
        check({tag, "_rerr"}, bus.record_err, m_rerr);
        check({tag, "_pulses"}, dut_pulses - pulse_base, m_pulses);
    endtask

    initial begin
        logic [13:0] s;
        bus.rx = 1'b1;
        bus.clear = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        repeat (3) @(negedge clk);
        check_all("reset");
        check("reset_byte", bus.byte_data, 8'h00);

        for (int i = 0; i < 32; i++) send_record(14'(i * 500), 8'(i));
        for (int i = 0; i < 32; i++) check("lin_wave", bus.waveform[i], i * 500);
        check("lin_pulses", dut_pulses - pulse_base, 1);
        check_all("lin");
        send_record(14'($urandom_range(0, 16383)), 8'($urandom_range(0, 31)));
        check_all("overwrite");

        do_clear();
        check_all("clear");
        send_byte(8'h45, 1'b1);
        send_byte(8'($urandom), 1'b1);
        send_byte(8'($urandom_range(0, 31)), 1'b1);
        check("hi45_mask", bus.sample_mask, 32'h0);
        send_record(14'($urandom_range(0, 16383)), 8'($urandom_range(0, 31)));
        send_record(14'($urandom_range(0, 16383)), 8'($urandom_range(32, 255)));
        check_all("rec_err");

        do_clear();
        send_byte(8'($urandom_range(0, 63)), 1'b1);
        send_byte(8'($urandom), 1'b0);
        send_record(14'($urandom_range(0, 16383)), 8'($urandom_range(0, 31)));
        check_all("frame_err");

        do_clear();
        send_byte(8'($urandom_range(0, 63)), 1'b1);
        send_byte(8'($urandom), 1'b1);
        repeat (40 * CPB) @(negedge clk);
        m_q.delete();
        s = 14'($urandom_range(0, 16383));
        send_record(s, 8'd7);
        check("gap_mask", bus.sample_mask, 32'h0000_0080);
        check("gap_wave7", bus.waveform[7], s);
        check_all("gap");

        do_clear();
        for (int i = 31; i >= 0; i--) begin
            send_record(14'($urandom_range(0, 16383)), 8'(i));
            if (i == 5) send_record(14'($urandom_range(0, 16383)), 8'd5);
            if (i == 1) check("desc_early_pulse", dut_pulses - pulse_base, 0);
        end
        check("desc_pulses", dut_pulses - pulse_base, 1);
        check_all("desc");

        bus.rx = 1'b0;
        repeat (CPB) @(negedge clk);
        bus.rx = 1'b1;
        repeat (3 * CPB / 2) @(negedge clk);
        rst_n = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        repeat (12 * CPB) @(negedge clk);
        check_all("rst_mid");
        check("rst_mid_byte", bus.byte_data, 8'h00);
        send_byte(8'($urandom_range(0, 63)), 1'b1);
        do_clear();
        check("clr_mid_byte", bus.byte_data, 8'h00);
        send_record(14'($urandom_range(0, 16383)), 8'($urandom_range(0, 31)));
        check_all("clr_mid");

`ifdef RX_MAJORITY_VOTE_EN
        begin
            logic [7:0] g;
            int n0;
            g = 8'($urandom);
            n0 = n_bytes;
            send_bit(1'b0);
            for (int i = 0; i < 8; i++) begin
                bus.rx = g[i];
                repeat (CPB / 2) @(negedge clk);
                bus.rx = ~g[i];
                @(negedge clk);
                bus.rx = g[i];
                repeat (CPB / 2 - 1) @(negedge clk);
            end
            send_bit(1'b1);
            send_bit(1'b1);
            check("glitch_cnt", n_bytes - n0, 1);
            check("glitch_byte", last_byte, g);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
